// File: rtl/elastic_pipeline_pkg.sv
// elastic_pipeline_pkg: stage state type, mode constants and capacity helper for the elastic pipeline
package elastic_pipeline_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} stage_state_e;
  localparam int MODE_FULL = 0;
  localparam int MODE_FWD = 1;
  localparam int MODE_BYP = 2;
  function automatic int capacity(input int mode, input int num_stage);
    return mode == MODE_FULL ? 2 * num_stage : mode == MODE_FWD ? num_stage : 0;
  endfunction
endpackage

// File: rtl/elastic_pipeline_stage.sv
// elastic_stage: one valid/ready stage, skid buffer (MODE 0), forward register (MODE 1) or wire (MODE 2)
module elastic_stage
  import elastic_pipeline_pkg::*;
#(
  parameter int ELEM_WIDTH = 32,
  parameter int MODE = MODE_FULL,
  parameter bit DATA_RST = 1'b0
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [ELEM_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [ELEM_WIDTH-1:0] out_data,
  input  logic                  out_ready
);
  logic clr;
  assign clr = srst || flush;
  if (MODE == MODE_FULL) begin : g_full
    stage_state_e state_q, state_d;
    logic rdy_q, acc, drn, ld_main, ld_skid, mv_skid;
    logic [ELEM_WIDTH-1:0] main_q, skid_q;
    assign acc = in_valid && rdy_q;
    assign drn = out_valid && out_ready;
    assign in_ready = rdy_q;
    assign out_data = main_q;
    always_ff @(posedge clk) begin
      state_q <= clr ? EMPTY : state_d;
      rdy_q <= !srst && (flush || state_d != TWO);
      if (clr && DATA_RST) begin
        main_q <= '0;
        skid_q <= '0;
      end else begin
        if (ld_main) main_q <= in_data;
        else if (mv_skid) main_q <= skid_q;
        if (ld_skid) skid_q <= in_data;
      end
    end
    always_comb begin
      state_d = state_q;
      state_d = state_q == EMPTY ? (acc ? ONE : EMPTY)
              : state_q == ONE   ? (acc && !drn ? TWO : drn && !acc ? EMPTY : ONE)
              : (drn ? ONE : TWO);
    end
    always_comb begin
      out_valid = state_q != EMPTY;
      ld_main = acc && (state_q == EMPTY || drn);
      ld_skid = acc && !drn && state_q == ONE;
      mv_skid = drn && state_q == TWO;
    end
  end else if (MODE == MODE_FWD) begin : g_fwd
    logic valid_q;
    logic [ELEM_WIDTH-1:0] data_q;
    assign in_ready = !srst && (!valid_q || out_ready);
    assign out_valid = valid_q;
    assign out_data = data_q;
    always_ff @(posedge clk) begin
      valid_q <= clr ? 1'b0 : in_ready ? in_valid : valid_q;
      if (clr && DATA_RST) data_q <= '0;
      else if (in_ready && in_valid) data_q <= in_data;
    end
  end else begin : g_byp
    logic unused_byp;
    assign unused_byp = ^{clk, clr};
    assign in_ready = out_ready;
    assign out_valid = in_valid;
    assign out_data = in_data;
  end
endmodule

// File: rtl/elastic_pipeline.sv
// elastic_pipeline: NUM_STAGE chained valid/ready stages; define ELASTIC_PIPELINE_OCC_EN for the occ port
module elastic_pipeline
  import elastic_pipeline_pkg::*;
#(
  parameter int ELEM_WIDTH = 32,
  parameter int NUM_STAGE = 1,
  parameter int MODE = MODE_FULL,
  parameter bit DATA_RST = 1'b0,
  parameter int OCC_W = NUM_STAGE == 0 ? 1 : $clog2(2 * NUM_STAGE + 1)
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [ELEM_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [ELEM_WIDTH-1:0] out_data,
  input  logic                  out_ready
`ifdef ELASTIC_PIPELINE_OCC_EN
  ,
  output logic [OCC_W-1:0]      occ
`endif
);
  localparam bit BYP = MODE == MODE_BYP || NUM_STAGE == 0;
  if (BYP) begin : g_wire
    logic unused_wire;
    assign unused_wire = ^{clk, srst, flush};
    assign in_ready = out_ready;
    assign out_valid = in_valid;
    assign out_data = in_data;
  end else begin : g_chain
    logic v [NUM_STAGE+1];
    logic r [NUM_STAGE+1];
    logic [ELEM_WIDTH-1:0] d [NUM_STAGE+1];
    assign v[0] = in_valid;
    assign d[0] = in_data;
    assign in_ready = r[0];
    assign out_valid = v[NUM_STAGE];
    assign out_data = d[NUM_STAGE];
    assign r[NUM_STAGE] = out_ready;
    for (genvar i = 0; i < NUM_STAGE; i++) begin : g_stage
      elastic_stage #(
        .ELEM_WIDTH(ELEM_WIDTH),
        .MODE      (MODE),
        .DATA_RST  (DATA_RST)
      ) u_stage (
        .clk      (clk),
        .srst     (srst),
        .flush    (flush),
        .in_valid (v[i]),
        .in_data  (d[i]),
        .in_ready (r[i]),
        .out_valid(v[i+1]),
        .out_data (d[i+1]),
        .out_ready(r[i+1])
      );
    end
  end
`ifdef ELASTIC_PIPELINE_OCC_EN
  if (BYP) begin : g_occ_none
    assign occ = '0;
  end else begin : g_occ
    localparam int CAP = capacity(MODE, NUM_STAGE);
    logic acc, drn;
    assign acc = in_valid && in_ready;
    assign drn = out_valid && out_ready;
    always_ff @(posedge clk) begin
      occ <= (srst || flush) ? '0 : occ + OCC_W'(acc) - OCC_W'(drn);
      if (!(srst || flush)) begin
        assert (!(acc && !drn && occ == OCC_W'(CAP))) else $error("occ overflow beyond capacity %0d", CAP);
        assert (!(drn && !acc && occ == '0)) else $error("occ underflow below zero");
      end
    end
  end
`endif
endmodule

// File: tb/tb_elastic_pipeline.sv
// tb_elastic_pipeline: directed and random checks of elastic_pipeline configurations against a scoreboard
module tb_elastic_pipeline;
  logic clk = 1'b0;
  logic srst, flush, iv, orr;
  logic [31:0] id;
  logic [4:0] ir, ov;
  logic [31:0] od [5];
`ifdef ELASTIC_PIPELINE_OCC_EN
  logic [2:0] occ0, occ1, occ2, occ3;
  logic [0:0] occ4;
`endif
  int n_chk = 0, n_err = 0, n_out = 0;
  int sel = 0;
  bit mon_en = 1'b0;
  logic [31:0] q [$];
  bit stall_q = 1'b0;
  logic [31:0] hold_d;
  int sent, got, cyc, first, gaps, c;
  logic acc;
  always #5 clk = ~clk;
  elastic_pipeline #(.ELEM_WIDTH(32), .NUM_STAGE(3), .MODE(0), .DATA_RST(1'b0)) u0 (
    .clk(clk), .srst(srst), .flush(flush), .in_valid(iv), .in_data(id), .in_ready(ir[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_ready(orr)
`ifdef ELASTIC_PIPELINE_OCC_EN
    , .occ(occ0)
`endif
  );
  elastic_pipeline #(.ELEM_WIDTH(32), .NUM_STAGE(2), .MODE(0), .DATA_RST(1'b1)) u1 (
    .clk(clk), .srst(srst), .flush(flush), .in_valid(iv), .in_data(id), .in_ready(ir[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_ready(orr)
`ifdef ELASTIC_PIPELINE_OCC_EN
    , .occ(occ1)
`endif
  );
  elastic_pipeline #(.ELEM_WIDTH(32), .NUM_STAGE(3), .MODE(1), .DATA_RST(1'b0)) u2 (
    .clk(clk), .srst(srst), .flush(flush), .in_valid(iv), .in_data(id), .in_ready(ir[2]),
    .out_valid(ov[2]), .out_data(od[2]), .out_ready(orr)
`ifdef ELASTIC_PIPELINE_OCC_EN
    , .occ(occ2)
`endif
  );
  elastic_pipeline #(.ELEM_WIDTH(32), .NUM_STAGE(2), .MODE(2), .DATA_RST(1'b0)) u3 (
    .clk(clk), .srst(srst), .flush(flush), .in_valid(iv), .in_data(id), .in_ready(ir[3]),
    .out_valid(ov[3]), .out_data(od[3]), .out_ready(orr)
`ifdef ELASTIC_PIPELINE_OCC_EN
    , .occ(occ3)
`endif
  );
  elastic_pipeline #(.ELEM_WIDTH(32), .NUM_STAGE(0), .MODE(0), .DATA_RST(1'b0)) u4 (
    .clk(clk), .srst(srst), .flush(flush), .in_valid(iv), .in_data(id), .in_ready(ir[4]),
    .out_valid(ov[4]), .out_data(od[4]), .out_ready(orr)
`ifdef ELASTIC_PIPELINE_OCC_EN
    , .occ(occ4)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    srst = 1'b1;
    flush = 1'b0;
    iv = 1'b0;
    @(posedge clk);
    #1;
    srst = 1'b0;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!mon_en) stall_q = 1'b0;
    else begin
      if (stall_q) begin
        chk("hold_valid", 32'(ov[sel]), 32'd1);
        chk("hold_data", od[sel], hold_d);
      end
      if (ov[sel] && orr) begin
        n_out++;
        chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) chk("sb_data", od[sel], q.pop_front());
      end
      stall_q = ov[sel] && !orr && !srst && !flush;
      hold_d = od[sel];
      if (srst || flush) q.delete();
      else if (iv && ir[sel]) q.push_back(id);
    end
  end
  initial begin
    #1_500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    srst = 1'b1;
    flush = 1'b0;
    iv = 1'b1;
    id = 32'hA5A5_A5A5;
    orr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", 32'(ir[k]), 32'd0);
      chk("rst_out_valid", 32'(ov[k]), 32'd0);
    end
    chk("rst_data_clr", od[1], 32'd0);
    srst = 1'b0;
    iv = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk("rst_release_ready", 32'(ir[k]), 32'd1);
    sel = 0;
    mon_en = 1'b1;
    do_reset();
    iv = 1'b1;
    id = 32'd0;
    sent = 0;
    got = 0;
    cyc = 0;
    first = -1;
    gaps = 0;
    while (got < 100 && cyc < 300) begin
      @(negedge clk);
      if (ov[0]) begin
        if (first < 0) first = cyc;
        got++;
      end else if (first >= 0) gaps++;
      acc = iv && ir[0];
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        sent++;
        id = 32'(sent);
        iv = sent < 100;
      end
    end
    chk("stream_latency", 32'(first), 32'd3);
    chk("stream_count", 32'(got), 32'd100);
    chk("stream_gaps", 32'(gaps), 32'd0);
    sel = 1;
    do_reset();
    orr = 1'b0;
    iv = 1'b1;
    id = 32'd100;
    sent = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      acc = iv && ir[1];
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        id = 32'(100 + sent);
      end
    end
    chk("bp_accepted", 32'(sent), 32'd4);
    chk("bp_in_ready", 32'(ir[1]), 32'd0);
    chk("bp_out_valid", 32'(ov[1]), 32'd1);
`ifdef ELASTIC_PIPELINE_OCC_EN
    chk("bp_occ", 32'(occ1), 32'd4);
`endif
    iv = 1'b0;
    n_out = 0;
    orr = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("bp_delivered", 32'(n_out), 32'd4);
    chk("bp_sb_empty", 32'(q.size()), 32'd0);
    sel = 2;
    do_reset();
    n_out = 0;
    sent = 0;
    cyc = 0;
    iv = 1'b1;
    id = $urandom;
    orr = 1'b1;
    while (sent < 10000 && cyc < 60000) begin
      @(negedge clk);
      acc = iv && ir[2];
      @(posedge clk);
      #1;
      cyc++;
      if (acc) sent++;
      if (acc || !iv) begin
        iv = ($urandom_range(3) != 0);
        id = $urandom;
      end
      orr = ($urandom_range(3) != 0);
    end
    iv = 1'b0;
    orr = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rand_sent", 32'(sent), 32'd10000);
    chk("rand_delivered", 32'(n_out), 32'd10000);
    chk("rand_sb_empty", 32'(q.size()), 32'd0);
    sel = 0;
    do_reset();
    orr = 1'b0;
    iv = 1'b1;
    id = 32'd200;
    sent = 0;
    cyc = 0;
    while (sent < 3 && cyc < 20) begin
      @(negedge clk);
      acc = iv && ir[0];
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        sent++;
        id = 32'(200 + sent);
      end
    end
    iv = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("flush_pre_valid", 32'(ov[0]), 32'd1);
`ifdef ELASTIC_PIPELINE_OCC_EN
    chk("flush_pre_occ", 32'(occ0), 32'd3);
`endif
    flush = 1'b1;
    iv = 1'b1;
    id = 32'h0000_0BAD;
    @(posedge clk);
    #1;
    flush = 1'b0;
    iv = 1'b0;
    chk("flush_out_valid", 32'(ov[0]), 32'd0);
`ifdef ELASTIC_PIPELINE_OCC_EN
    chk("flush_occ", 32'(occ0), 32'd0);
`endif
    orr = 1'b1;
    iv = 1'b1;
    id = 32'h77;
    c = 0;
    while (c < 20) begin
      @(negedge clk);
      if (ov[0]) break;
      @(posedge clk);
      #1;
      iv = 1'b0;
      c++;
    end
    iv = 1'b0;
    chk("flush_next_latency", 32'(c), 32'd3);
    repeat (3) @(posedge clk);
    #1;
    chk("flush_sb_empty", 32'(q.size()), 32'd0);
    mon_en = 1'b0;
    for (int k = 3; k < 5; k++) begin
      for (int t = 0; t < 4; t++) begin
        orr = t[0];
        srst = (t == 2);
        iv = (t != 3);
        id = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("wire_data", od[k], 32'hDEAD_BEEF);
        chk("wire_ready", 32'(ir[k]), 32'(orr));
        chk("wire_valid", 32'(ov[k]), 32'(iv));
        @(posedge clk);
        #1;
      end
    end
    srst = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
